uart_tx: RTL and testbench

Byte-wide UART transmitter that drives the FPGA-to-BLE-module serial line (`ble_uart_rx` at top level) at the same bit rate as the existing BLE receive path. It buffers outgoing bytes in a small FIFO behind a valid/ready handshake and emits 8N1 frames LSB-first. It honours the BLE module's hardware flow control (`ble_uart_rts`) at frame boundaries. It runs in the pixel clock domain (74.25 MHz), so game logic (score, state) can stream telemetry without stalling.

---
 rtl/uart_tx_if.sv | 10 +
 rtl/uart_tx.sv | 175 +++++++++++++++++
 tb/tb_uart_tx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Byte handshake between an upstream producer and the uart_tx FIFO.
// A byte transfers on a clock edge where valid_in && ready_out.
interface uart_tx_if;
    logic [7:0] data_in;
    logic       valid_in;
    logic       ready_out;

    modport master (output data_in, output valid_in, input  ready_out);
    modport slave  (input  data_in, input  valid_in, output ready_out);
endinterface

// File: rtl/uart_tx.sv
// FIFO-buffered 8N1 UART transmitter with CTS flow control sampled at frame start.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 frames).
module uart_tx #(
    parameter int unsigned BAUD_COUNT = 645,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    uart_tx_if.slave                 bus,
    input  logic                     cts_n_in,
    output logic                     tx_out,
    output logic                     busy_out,
    output logic [$clog2(DEPTH):0]   count_out
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = $clog2(BAUD_COUNT);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    state_t          r_state, w_state_nx;
    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr, r_rd;
    logic [CW-1:0]   r_count;
    logic            r_cts_meta, r_cts_s;
    logic [7:0]      r_shift, w_shift_nx;
    logic [BW-1:0]   r_baud, w_baud_nx;
    logic [2:0]      r_bit, w_bit_nx;
    logic            r_tx, w_tx_nx;
    logic            r_busy, w_busy_nx;
    logic            w_push, w_pop, w_ready, w_tc, w_can_start;
    logic [7:0]      w_head;
`ifdef UART_TX_PARITY_EN
    logic            r_par, w_par_nx;
`endif

    assign w_ready       = (r_count != CW'(DEPTH));
    assign bus.ready_out = w_ready;
    assign w_push        = bus.valid_in && w_ready;
    assign w_head        = r_mem[r_rd];
    assign w_tc          = (r_baud == BW'(BAUD_COUNT - 1));
    assign w_can_start   = (r_count != '0) && !r_cts_s;

    assign tx_out    = r_tx;
    assign busy_out  = r_busy;
    assign count_out = r_count;

    // Two-flop synchronizer; reset to "not clear" so nothing starts before CTS is seen
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_cts_meta <= 1'b1;
            r_cts_s    <= 1'b1;
        end else begin
            r_cts_meta <= cts_n_in;
            r_cts_s    <= r_cts_meta;
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_push) r_mem[r_wr] <= bus.data_in;
    end

    // Pointers wrap naturally; occupancy tracks push/pop independently
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) r_state <= S_IDLE;
        else           r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_can_start) begin
                    w_pop      = 1'b1;
                    w_state_nx = S_START;
                end
            end
            S_START: if (w_tc) w_state_nx = S_DATA;
            S_DATA: begin
                if (w_tc && (r_bit == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
                    w_state_nx = S_PARITY;
`else
                    w_state_nx = S_STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (w_tc) w_state_nx = S_STOP;
`endif
            S_STOP: begin
                if (w_tc) begin
                    if (w_can_start) begin
                        w_pop      = 1'b1;
                        w_state_nx = S_START;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Next datapath/line values; the line is registered from the next state
    always_comb begin
        w_shift_nx = r_shift;
        w_bit_nx   = r_bit;
        w_baud_nx  = (r_state == S_IDLE || w_tc) ? '0 : r_baud + BW'(1);
`ifdef UART_TX_PARITY_EN
        w_par_nx   = r_par;
`endif
        if (w_pop) begin
            w_shift_nx = w_head;
            w_bit_nx   = 3'd0;
            w_baud_nx  = '0;
`ifdef UART_TX_PARITY_EN
            w_par_nx   = ^w_head;
`endif
        end else if (w_tc && r_state == S_DATA) begin
            w_shift_nx = {1'b0, r_shift[7:1]};
            w_bit_nx   = r_bit + 3'd1;
        end else if (w_tc && r_state == S_START) begin
            w_bit_nx   = 3'd0;
        end
        case (w_state_nx)
            S_START:  w_tx_nx = 1'b0;
            S_DATA:   w_tx_nx = w_shift_nx[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: w_tx_nx = w_par_nx;
`endif
            default:  w_tx_nx = 1'b1;
        endcase
        w_busy_nx = (w_state_nx != S_IDLE);
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_shift <= '0;
            r_bit   <= '0;
            r_baud  <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_shift <= w_shift_nx;
            r_bit   <= w_bit_nx;
            r_baud  <= w_baud_nx;
            r_tx    <= w_tx_nx;
            r_busy  <= w_busy_nx;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par_nx;
`endif
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with BAUD_COUNT=4, DEPTH=16.
// Covers reset, single frame, full FIFO drain, CTS mid-frame, push/pop overlap, mid-frame reset, parity.
module tb_uart_tx;
    localparam int unsigned BAUD  = 4;
    localparam int unsigned DEPTH = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    logic       cts_n_in;
    logic       tx_out;
    logic       busy_out;
    logic [4:0] count_out;
    int         n_cmp = 0;
    int         n_err = 0;

    uart_tx_if u_if ();

    uart_tx #(.BAUD_COUNT(BAUD), .DEPTH(DEPTH)) dut (
        .clk_in    (clk_in),
        .rst_n_in  (rst_n_in),
        .bus       (u_if.slave),
        .cts_n_in  (cts_n_in),
        .tx_out    (tx_out),
        .busy_out  (busy_out),
        .count_out (count_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (FRAME_BITS == 11 && b == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic push(input logic [7:0] d);
        u_if.data_in  = d;
        u_if.valid_in = 1'b1;
        tick();
        u_if.valid_in = 1'b0;
    endtask

    // Entered right after the edge that starts the frame; leaves right after the edge that ends it
    task automatic expect_frame(input logic [7:0] d, input int cts_at, input int push_at,
                                input logic [7:0] push_d);
        for (int k = 0; k < FRAME_BITS * int'(BAUD); k++) begin
            chk($sformatf("frame_%02h_k%0d", d, k), 32'(tx_out), 32'(exp_bit(d, k / int'(BAUD))));
            if (k == 0) chk("frame_busy", 32'(busy_out), 32'd1);
            if (k == cts_at) cts_n_in = 1'b1;
            if (k == push_at) begin
                u_if.data_in  = push_d;
                u_if.valid_in = 1'b1;
            end
            tick();
            if (k == push_at) u_if.valid_in = 1'b0;
        end
    endtask

    task automatic expect_idle(input string tag, input logic [4:0] cnt);
        chk({tag, "_tx"},    32'(tx_out),    32'd1);
        chk({tag, "_busy"},  32'(busy_out),  32'd0);
        chk({tag, "_count"}, 32'(count_out), 32'(cnt));
    endtask

    initial begin
        rst_n_in      = 1'b0;
        cts_n_in      = 1'b0;
        u_if.data_in  = 8'h00;
        u_if.valid_in = 1'b0;

        // Reset state
        tick(); tick();
        expect_idle("reset", 5'd0);
        chk("reset_ready", 32'(u_if.ready_out), 32'd1);
        rst_n_in = 1'b1;
        tick(); tick(); tick();

        // Single byte 0xA5
        push(8'hA5);
        chk("single_count_after_push", 32'(count_out), 32'd1);
        chk("single_tx_before_start", 32'(tx_out), 32'd1);
        tick();
        chk("single_count_after_pop", 32'(count_out), 32'd0);
        expect_frame(8'hA5, -1, -1, 8'h00);
        expect_idle("single_end", 5'd0);

        // Full FIFO, then drain back-to-back
        cts_n_in = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 17; i++) begin
            chk($sformatf("full_ready_%0d", i), 32'(u_if.ready_out), (i == 16) ? 32'd0 : 32'd1);
            push(8'(8'h10 + i));
        end
        expect_idle("full", 5'd16);
        chk("full_ready", 32'(u_if.ready_out), 32'd0);
        cts_n_in = 1'b0;
        tick();
        chk("drain_lat1", 32'(tx_out), 32'd1);
        tick();
        chk("drain_lat2", 32'(tx_out), 32'd1);
        tick();
        chk("drain_count_first", 32'(count_out), 32'd15);
        for (int i = 0; i < 16; i++) expect_frame(8'(8'h10 + i), -1, -1, 8'h00);
        expect_idle("drain_end", 5'd0);

        // CTS raised during data bit 3 with two bytes queued
        cts_n_in = 1'b1;
        tick(); tick(); tick();
        push(8'h3C);
        push(8'hC3);
        cts_n_in = 1'b0;
        tick(); tick(); tick();
        expect_frame(8'h3C, 4 * int'(BAUD) + 1, -1, 8'h00);
        expect_idle("cts_held", 5'd1);
        for (int i = 0; i < 6; i++) tick();
        expect_idle("cts_still_held", 5'd1);
        cts_n_in = 1'b0;
        tick();
        chk("cts_lat1", 32'(tx_out), 32'd1);
        tick();
        chk("cts_lat2", 32'(tx_out), 32'd1);
        tick();
        expect_frame(8'hC3, -1, -1, 8'h00);
        expect_idle("cts_end", 5'd0);

        // Push on the same edge that STOP pops the next head
        cts_n_in = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 6; i++) push(8'(8'h50 + i));
        chk("pp_count_queued", 32'(count_out), 32'd6);
        cts_n_in = 1'b0;
        tick(); tick(); tick();
        chk("pp_count_first", 32'(count_out), 32'd5);
        expect_frame(8'h50, -1, FRAME_BITS * int'(BAUD) - 1, 8'h56);
        chk("pp_count_same", 32'(count_out), 32'd5);
        for (int i = 1; i < 7; i++) expect_frame(8'(8'h50 + i), -1, -1, 8'h00);
        expect_idle("pp_end", 5'd0);

        // Reset during data bit 4 with three bytes queued
        cts_n_in = 1'b1;
        tick(); tick(); tick();
        push(8'h61);
        push(8'h62);
        push(8'h63);
        cts_n_in = 1'b0;
        tick(); tick(); tick();
        chk("rst_frame_started", 32'(tx_out), 32'd0);
        for (int i = 0; i < 5 * int'(BAUD) + 1; i++) tick();
        chk("rst_in_bit4", 32'(tx_out), 32'(exp_bit(8'h61, 5)));
        rst_n_in = 1'b0;
        tick();
        expect_idle("rst_mid", 5'd0);
        rst_n_in = 1'b1;
        for (int i = 0; i < 12 * int'(BAUD); i++) begin
            tick();
            chk($sformatf("rst_quiet_%0d", i), 32'(tx_out), 32'd1);
        end
        expect_idle("rst_after", 5'd0);

`ifdef UART_TX_PARITY_EN
        // Even parity: 0x07 gives 1, 0x03 gives 0
        push(8'h07);
        tick();
        chk("par07_bit", 32'(exp_bit(8'h07, 9)), 32'd1);
        expect_frame(8'h07, -1, -1, 8'h00);
        expect_idle("par07_end", 5'd0);
        push(8'h03);
        tick();
        expect_frame(8'h03, -1, -1, 8'h00);
        expect_idle("par03_end", 5'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
